// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: opcodes, FSM encoding
// and a magnitude helper used when latching signed operands.
package multdiv_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // Magnitude of a two's complement value; 32'h80000000 maps to itself as unsigned 2^31.
  function automatic logic [WIDTH-1:0] mag32(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/multdiv_core.sv
// Datapath for the md unit: one radix-2 shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on unsigned magnitudes.
module multdiv_core
  import multdiv_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     mag_a_i,
  input  logic [WIDTH-1:0]     mag_b_i,
  output logic [2*WIDTH-1:0]   acc_next_o,
  output logic [4:0]           count_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [4:0]         cnt_q, cnt_d;

  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH:0]   shl_s;
  logic [WIDTH+1:0]   diff_s;
  logic [WIDTH:0]     sum_s;

  // Single iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    step_s = acc_q;
    shl_s  = {acc_q, 1'b0};
    diff_s = {1'b0, shl_s[2*WIDTH:WIDTH]} - {2'b00, opnd_q};
    sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    if (is_div_q) begin
      if (!diff_s[WIDTH+1]) begin
        step_s = {diff_s[WIDTH-1:0], shl_s[WIDTH-1:1], 1'b1};
      end else begin
        step_s = shl_s[2*WIDTH-1:0];
      end
    end else begin
      step_s = {sum_s, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = {{WIDTH{1'b0}}, (is_div_i ? mag_a_i : mag_b_i)};
      opnd_d   = is_div_i ? mag_b_i : mag_a_i;
      is_div_d = is_div_i;
      cnt_d    = 5'd0;
    end else if (step_i) begin
      acc_d = step_s;
      cnt_d = cnt_q + 5'd1;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      cnt_q    <= 5'd0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_next_o = step_s;
  assign count_o    = cnt_q;

endmodule

// File: rtl/multdiv_unit.sv
// Execute-stage multiply/divide unit: FSM, operand sign latch, result sign fix-up
// and exception detection around the iterative multdiv_core datapath.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataA_from_dx,
  input  logic [WIDTH-1:0] dataB_from_dx,
  input  logic [4:0]       ALUOp_from_dx,
  input  logic [4:0]       regDst_from_dx,
  output logic             stall_md,
  output logic             md_ready,
  output logic [WIDTH-1:0] md_result,
  output logic             md_exception,
  output logic [4:0]       md_regDst
);

  logic [1:0]         state_q, state_d;
  logic               neg_q, neg_d;
  logic               is_div_q, is_div_d;
  logic               ovf_q, ovf_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic [4:0]         rd_out_q, rd_out_d;

  logic               is_md_op_s, start_s, div_zero_s, finish_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [4:0]         count_s;
  logic [WIDTH-1:0]   fix_result_s;
  logic               fix_exc_s;

  // Reset gates start so stall_md falls at once even with the md op still in D/X
  assign is_md_op_s = (ALUOp_from_dx == OP_MUL) || (ALUOp_from_dx == OP_DIV);
  assign start_s    = ~reset & (state_q == ST_IDLE) & ~flush & is_md_op_s;
  assign div_zero_s = (ALUOp_from_dx == OP_DIV) && (dataB_from_dx == 32'd0);
  assign finish_s   = (state_q == ST_BUSY) & ~flush & (count_s == LAST_ITER);

  multdiv_core u_core (
    .clock      (clock),
    .reset      (reset),
    .load_i     (start_s),
    .step_i     ((state_q == ST_BUSY) & ~flush),
    .is_div_i   (ALUOp_from_dx == OP_DIV),
    .mag_a_i    (mag32(dataA_from_dx)),
    .mag_b_i    (mag32(dataB_from_dx)),
    .acc_next_o (acc_next_s),
    .count_o    (count_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = div_zero_s ? ST_DONE : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (count_s == LAST_ITER) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Product magnitude must fit 2^31-1 (positive) or 2^31 (negative); div only overflows on MIN/-1
  always_comb begin
    fix_result_s = neg_q ? (32'd0 - acc_next_s[WIDTH-1:0]) : acc_next_s[WIDTH-1:0];
    if (is_div_q) begin
      fix_exc_s = ovf_q;
    end else if (neg_q) begin
      fix_exc_s = (acc_next_s > 64'h0000_0000_8000_0000);
    end else begin
      fix_exc_s = (acc_next_s > 64'h0000_0000_7FFF_FFFF);
    end
  end

  always_comb begin
    neg_d    = neg_q;
    is_div_d = is_div_q;
    ovf_d    = ovf_q;
    rd_d     = rd_q;
    result_d = result_q;
    exc_d    = exc_q;
    rd_out_d = rd_out_q;
    if (start_s) begin
      neg_d    = dataA_from_dx[WIDTH-1] ^ dataB_from_dx[WIDTH-1];
      is_div_d = (ALUOp_from_dx == OP_DIV);
      ovf_d    = (dataA_from_dx == 32'h8000_0000) && (dataB_from_dx == 32'hFFFF_FFFF);
      rd_d     = regDst_from_dx;
    end else begin
      rd_d = rd_q;
    end
    if (start_s && div_zero_s) begin
      result_d = 32'd0;
      exc_d    = 1'b1;
      rd_out_d = regDst_from_dx;
    end else if (finish_s) begin
      result_d = fix_result_s;
      exc_d    = fix_exc_s;
      rd_out_d = rd_q;
    end else begin
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= {WIDTH{1'b0}};
      exc_q    <= 1'b0;
      rd_out_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign stall_md     = start_s | (state_q == ST_BUSY);
  assign md_ready     = (state_q == ST_DONE) & ~flush;
  assign md_result    = result_q;
  assign md_exception = exc_q;
  assign md_regDst    = rd_out_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized self-checking bench for multdiv_unit against a plain-arithmetic reference model.
module tb_multdiv_unit;

  localparam logic [4:0] OPC_MUL = 5'b00110;
  localparam logic [4:0] OPC_DIV = 5'b00111;
  localparam logic [4:0] OPC_NOP = 5'b00000;
  localparam longint S32_MAX = 64'sd2147483647;
  localparam longint S32_MIN = -64'sd2147483648;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] dataA_from_dx = 32'd0;
  logic [31:0] dataB_from_dx = 32'd0;
  logic [4:0]  ALUOp_from_dx = 5'd0;
  logic [4:0]  regDst_from_dx = 5'd0;
  logic        stall_md, md_ready, md_exception;
  logic [31:0] md_result;
  logic [4:0]  md_regDst;

  int n_checks = 0;
  int n_fail = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .dataA_from_dx  (dataA_from_dx),
    .dataB_from_dx  (dataB_from_dx),
    .ALUOp_from_dx  (ALUOp_from_dx),
    .regDst_from_dx (regDst_from_dx),
    .stall_md       (stall_md),
    .md_ready       (md_ready),
    .md_result      (md_result),
    .md_exception   (md_exception),
    .md_regDst      (md_regDst)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic and truncating signed division
  task automatic ref_md(input logic [31:0] a, input logic [31:0] b, input bit is_div,
                        output logic [31:0] r, output logic e, output int lat);
    longint p;
    int     q;
    if (!is_div) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[31:0];
      e   = (p > S32_MAX) || (p < S32_MIN);
      lat = 33;
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1; lat = 33;
    end else begin
      q = $signed(a) / $signed(b);
      r = q; e = 1'b0; lat = 33;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit is_div, input logic [4:0] rd);
    logic [31:0] er;
    logic        ee;
    int          elat;
    int          lat;
    bit          seen;
    ref_md(a, b, is_div, er, ee, elat);
    @(negedge clock);
    dataA_from_dx  = a;
    dataB_from_dx  = b;
    ALUOp_from_dx  = is_div ? OPC_DIV : OPC_MUL;
    regDst_from_dx = rd;
    #1 check_eq("stall_start", {31'd0, stall_md}, 32'd1);
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clock);
      if (md_ready) begin
        seen = 1'b1; lat = c;
      end else begin
        check_eq("stall_busy", {31'd0, stall_md}, 32'd1);
      end
    end
    check_eq("ready_seen", {31'd0, seen}, 32'd1);
    check_eq("latency", lat, elat);
    if (seen) begin
      check_eq("stall_done", {31'd0, stall_md}, 32'd0);
      check_eq("result", md_result, er);
      check_eq("exception", {31'd0, md_exception}, {31'd0, ee});
      check_eq("regdst", {27'd0, md_regDst}, {27'd0, rd});
    end
    ALUOp_from_dx = OPC_NOP;
    @(negedge clock);
    check_eq("ready_once", {31'd0, md_ready}, 32'd0);
    check_eq("idle_stall", {31'd0, stall_md}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand(input int kind);
    logic [31:0] v;
    case (kind)
      0: v = $urandom_range(2000) - 1000;
      1: v = $urandom;
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      4: v = 32'd0;
      default: v = $urandom_range(70000);
    endcase
    return v;
  endfunction

  initial begin
    int pulses, first_c, second_c;
    logic [31:0] er;
    logic ee;
    int elat;

    #2 reset = 1'b1;
    #1;
    check_eq("rst_stall", {31'd0, stall_md}, 32'd0);
    check_eq("rst_ready", {31'd0, md_ready}, 32'd0);
    check_eq("rst_result", md_result, 32'd0);
    check_eq("rst_exc", {31'd0, md_exception}, 32'd0);
    check_eq("rst_regdst", {27'd0, md_regDst}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_op(32'd7, 32'hFFFF_FFFD, 1'b0, 5'd3);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 5'd9);
    run_op(32'd5, 32'd0, 1'b1, 5'd17);
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 5'd4);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd30);
    run_op(32'h8000_0000, 32'd1, 1'b0, 5'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd2);

    for (int i = 0; i < 30; i++) begin
      run_op(pick_operand($urandom_range(5)), pick_operand($urandom_range(5)),
             1'($urandom_range(1)), 5'($urandom_range(31)));
    end

    // Flush mid-multiply
    @(negedge clock);
    dataA_from_dx = 32'd11; dataB_from_dx = 32'd13;
    ALUOp_from_dx = OPC_MUL; regDst_from_dx = 5'd6;
    repeat (10) @(negedge clock);
    flush = 1'b1;
    #1 check_eq("flush_no_ready", {31'd0, md_ready}, 32'd0);
    @(negedge clock);
    check_eq("flush_stall", {31'd0, stall_md}, 32'd0);
    flush = 1'b0; ALUOp_from_dx = OPC_NOP;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (md_ready) pulses++;
    end
    check_eq("flush_pulses", pulses, 32'd0);
    run_op(32'd11, 32'd13, 1'b0, 5'd6);

    // Back-to-back multiplies with D/X held
    ref_md(32'd123, 32'hFFFF_FFD3, 1'b0, er, ee, elat);
    @(negedge clock);
    dataA_from_dx = 32'd123; dataB_from_dx = 32'hFFFF_FFD3;
    ALUOp_from_dx = OPC_MUL; regDst_from_dx = 5'd21;
    pulses = 0; first_c = 0; second_c = 0;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clock);
      if (md_ready) begin
        pulses++;
        if (pulses == 1) first_c = c;
        if (pulses == 2) begin
          second_c = c;
          ALUOp_from_dx = OPC_NOP;
        end
        check_eq("b2b_result", md_result, er);
      end
    end
    check_eq("b2b_pulses", pulses, 32'd2);
    check_eq("b2b_first", first_c, 32'd33);
    check_eq("b2b_gap", second_c - first_c, 32'd34);

    // Async reset mid-operation
    @(negedge clock);
    dataA_from_dx = 32'd9; dataB_from_dx = 32'd9; ALUOp_from_dx = OPC_MUL;
    repeat (5) @(negedge clock);
    check_eq("pre_rst_stall", {31'd0, stall_md}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_stall", {31'd0, stall_md}, 32'd0);
    check_eq("async_rst_result", md_result, 32'd0);
    ALUOp_from_dx = OPC_NOP;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_stall", {31'd0, stall_md}, 32'd0);
    run_op(32'hFFFF_FFF6, 32'hFFFF_FFFD, 1'b1, 5'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
